// File: rtl/rf_hazard_unit_if.sv
// Issue-side bundle between the ID stage and the register-file hazard/bypass unit.
// The ID stage drives requests and operand data; the unit answers with stall, fire and resolved operands.
interface rf_hazard_unit_if #(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2
);
  logic                  iss_valid;
  logic                  iss_we;
  logic [AW-1:0]         iss_rd;
  logic                  iss_load;
  logic [NSRC-1:0]       src_en;
  logic [NSRC*AW-1:0]    src_addr;
  logic [NSRC*32-1:0]    rf_rdata;
  logic [DEPTH*32-1:0]   stage_wdata;
  logic                  flush;
  logic                  iss_stall;
  logic                  iss_fire;
  logic [NSRC*32-1:0]    src_data;
  logic [DEPTH-1:0]      slot_vld;
  logic [31:0]           stall_cnt;

  modport master (
    output iss_valid, iss_we, iss_rd, iss_load, src_en, src_addr, rf_rdata, stage_wdata, flush,
    input  iss_stall, iss_fire, src_data, slot_vld, stall_cnt
  );

  modport slave (
    input  iss_valid, iss_we, iss_rd, iss_load, src_en, src_addr, rf_rdata, stage_wdata, flush,
    output iss_stall, iss_fire, src_data, slot_vld, stall_cnt
  );
endinterface

// File: rtl/rf_hazard_unit.sv
// Register-file hazard and bypass unit: tracks in-flight writers (slot 0 = EXE .. DEPTH-1 = WB)
// and either stalls issue or forwards the youngest matching result to each source operand.
module rf_hazard_unit #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int NSRC     = 2,
  parameter int FWD_EN   = 1,
  parameter int LOAD_RDY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  rf_hazard_unit_if.slave   bus
);

  localparam int unsigned LOAD_RDY_U = LOAD_RDY;

  typedef struct packed {
    logic          vld;
    logic          we;
    logic [AW-1:0] rd;
    logic          load;
  } slot_t;

  slot_t              r_slot [DEPTH];
  logic [31:0]        r_stall_cnt;

  logic               w_any_stall;
  logic               w_stall;
  logic               w_fire;
  logic               w_hit;
  logic               w_hit_load;
  logic               w_hit_early;
  logic [31:0]        w_hit_data;
  logic [NSRC*32-1:0] w_src_data;
  logic [DEPTH-1:0]   w_slot_vld;

  // Slots are scanned oldest to youngest so the youngest match overwrites and wins.
  always_comb begin
    w_any_stall = 1'b0;
    w_src_data  = bus.rf_rdata;
    w_hit       = 1'b0;
    w_hit_load  = 1'b0;
    w_hit_early = 1'b0;
    w_hit_data  = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      w_hit       = 1'b0;
      w_hit_load  = 1'b0;
      w_hit_early = 1'b0;
      w_hit_data  = '0;
      for (int unsigned n = DEPTH; n > 0; n--) begin
        if (bus.src_en[i] && (bus.src_addr[i*AW +: AW] != '0) &&
            r_slot[n-1].vld && r_slot[n-1].we &&
            (r_slot[n-1].rd == bus.src_addr[i*AW +: AW])) begin
          w_hit       = 1'b1;
          w_hit_load  = r_slot[n-1].load;
          w_hit_early = ((n - 1) < LOAD_RDY_U);
          w_hit_data  = bus.stage_wdata[(n-1)*32 +: 32];
        end
      end
      if (w_hit) begin
        if ((FWD_EN == 0) || (w_hit_load && w_hit_early)) begin
          w_any_stall = 1'b1;
        end else begin
          w_src_data[i*32 +: 32] = w_hit_data;
        end
      end
    end
  end

  always_comb begin
    w_slot_vld = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_slot_vld[k] = r_slot[k].vld;
    end
  end

  assign w_stall       = bus.iss_valid & w_any_stall;
  assign w_fire        = bus.iss_valid & ~w_stall & ~bus.flush;
  assign bus.iss_stall = w_stall;
  assign bus.iss_fire  = w_fire;
  assign bus.src_data  = w_src_data;
  assign bus.slot_vld  = w_slot_vld;
  assign bus.stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_slot[k] <= '0;
      end
      r_stall_cnt <= '0;
    end else begin
      if (bus.flush) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          r_slot[k] <= '0;
        end
      end else begin
        r_slot[0] <= w_fire ? '{vld: 1'b1, we: bus.iss_we, rd: bus.iss_rd, load: bus.iss_load}
                            : '0;
        for (int unsigned k = 1; k < DEPTH; k++) begin
          r_slot[k] <= r_slot[k-1];
        end
      end
      if (w_stall && !bus.flush && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_hazard_unit.sv
// Directed bench: one forwarding unit (FWD_EN=1, LOAD_RDY=2) and one interlock unit (FWD_EN=0)
// driven by identical stimulus, each checked against hand-computed values.
module tb_rf_hazard_unit;

  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int NSRC  = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic                iss_valid;
  logic                iss_we;
  logic [AW-1:0]       iss_rd;
  logic                iss_load;
  logic [NSRC-1:0]     src_en;
  logic [AW-1:0]       a0;
  logic [AW-1:0]       a1;
  logic [NSRC*32-1:0]  rf_rdata;
  logic [DEPTH*32-1:0] stage_wdata;
  logic                flush;

  int n_chk = 0;
  int n_err = 0;

  rf_hazard_unit_if #(.AW(AW), .DEPTH(DEPTH), .NSRC(NSRC)) if_f ();
  rf_hazard_unit_if #(.AW(AW), .DEPTH(DEPTH), .NSRC(NSRC)) if_i ();

  assign if_f.iss_valid = iss_valid;   assign if_i.iss_valid = iss_valid;
  assign if_f.iss_we = iss_we;         assign if_i.iss_we = iss_we;
  assign if_f.iss_rd = iss_rd;         assign if_i.iss_rd = iss_rd;
  assign if_f.iss_load = iss_load;     assign if_i.iss_load = iss_load;
  assign if_f.src_en = src_en;         assign if_i.src_en = src_en;
  assign if_f.src_addr = {a1, a0};     assign if_i.src_addr = {a1, a0};
  assign if_f.rf_rdata = rf_rdata;     assign if_i.rf_rdata = rf_rdata;
  assign if_f.stage_wdata = stage_wdata; assign if_i.stage_wdata = stage_wdata;
  assign if_f.flush = flush;           assign if_i.flush = flush;

  rf_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .NSRC(NSRC), .FWD_EN(1), .LOAD_RDY(2))
    dut_fwd (.clk(clk), .resetn(resetn), .bus(if_f));
  rf_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .NSRC(NSRC), .FWD_EN(0), .LOAD_RDY(2))
    dut_ilk (.clk(clk), .resetn(resetn), .bus(if_i));

  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0001;
  localparam logic [31:0] SW0 = 32'h0000_1234;
  localparam logic [31:0] SW1 = 32'h0000_5678;
  localparam logic [31:0] SW2 = 32'h0000_9ABC;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] rd, input logic ld,
                       input logic [NSRC-1:0] en, input logic [AW-1:0] s0, input logic [AW-1:0] s1);
    iss_valid = v; iss_we = we; iss_rd = rd; iss_load = ld;
    src_en = en; a0 = s0; a1 = s1;
    #3;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(1'b0, 1'b0, '0, 1'b0, 2'b00, '0, '0);
    flush = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    rf_rdata    = {RF1, RF0};
    stage_wdata = {SW2, SW1, SW0};
    flush       = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0, 2'b11, 5'd5, 5'd5);
    tick();

    // Reset held with a valid reader present
    drive(1'b1, 1'b0, '0, 1'b0, 2'b11, 5'd5, 5'd5);
    check("rst_stall_f", {31'd0, if_f.iss_stall}, 32'd0);
    check("rst_stall_i", {31'd0, if_i.iss_stall}, 32'd0);
    check("rst_fire_f", {31'd0, if_f.iss_fire}, 32'd1);
    check("rst_src0", if_f.src_data[31:0], RF0);
    check("rst_src1", if_f.src_data[63:32], RF1);
    check("rst_slotvld", {29'd0, if_f.slot_vld}, 32'd0);
    check("rst_cnt", if_f.stall_cnt, 32'd0);
    do_reset();

    // ALU forward (fwd unit) and full interlock (ilk unit) on r5
    drive(1'b1, 1'b1, 5'd5, 1'b0, 2'b00, '0, '0);
    check("alu_fire_f", {31'd0, if_f.iss_fire}, 32'd1);
    check("alu_fire_i", {31'd0, if_i.iss_fire}, 32'd1);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b01, 5'd5, '0);
    check("alu_slotvld_f", {29'd0, if_f.slot_vld}, 32'd1);
    check("alu_stall_f0", {31'd0, if_f.iss_stall}, 32'd0);
    check("alu_fwd_k0", if_f.src_data[31:0], SW0);
    check("ilk_stall_c1", {31'd0, if_i.iss_stall}, 32'd1);
    check("ilk_fire_c1", {31'd0, if_i.iss_fire}, 32'd0);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b01, 5'd5, '0);
    check("alu_fwd_k1", if_f.src_data[31:0], SW1);
    check("ilk_stall_c2", {31'd0, if_i.iss_stall}, 32'd1);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b01, 5'd5, '0);
    check("alu_fwd_k2", if_f.src_data[31:0], SW2);
    check("ilk_stall_c3", {31'd0, if_i.iss_stall}, 32'd1);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b01, 5'd5, '0);
    check("ilk_release", {31'd0, if_i.iss_stall}, 32'd0);
    check("ilk_src_rf", if_i.src_data[31:0], RF0);
    check("ilk_cnt", if_i.stall_cnt, 32'd3);
    check("alu_cnt_f", if_f.stall_cnt, 32'd0);
    do_reset();

    // Load-use on r7 through source port 1
    drive(1'b1, 1'b1, 5'd7, 1'b1, 2'b00, '0, '0);
    check("ld_fire", {31'd0, if_f.iss_fire}, 32'd1);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b10, '0, 5'd7);
    check("ld_stall_c1", {31'd0, if_f.iss_stall}, 32'd1);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b10, '0, 5'd7);
    check("ld_stall_c2", {31'd0, if_f.iss_stall}, 32'd1);
    check("ld_cnt_mid", if_f.stall_cnt, 32'd1);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b10, '0, 5'd7);
    check("ld_release", {31'd0, if_f.iss_stall}, 32'd0);
    check("ld_fwd_k2", if_f.src_data[63:32], SW2);
    check("ld_src0_rf", if_f.src_data[31:0], RF0);
    check("ld_cnt", if_f.stall_cnt, 32'd2);
    do_reset();

    // r0 never matches; a non-writer never matches
    drive(1'b1, 1'b1, 5'd0, 1'b0, 2'b00, '0, '0);
    tick();
    drive(1'b1, 1'b0, 5'd9, 1'b0, 2'b01, 5'd0, '0);
    check("r0_stall_i", {31'd0, if_i.iss_stall}, 32'd0);
    check("r0_src", if_f.src_data[31:0], RF0);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b11, 5'd9, 5'd9);
    check("nowe_stall_i", {31'd0, if_i.iss_stall}, 32'd0);
    check("nowe_src1", if_i.src_data[63:32], RF1);
    do_reset();

    // Youngest wins: r4 writers in slots 0 and 2
    drive(1'b1, 1'b1, 5'd4, 1'b0, 2'b00, '0, '0);
    tick();
    drive(1'b1, 1'b0, 5'd4, 1'b0, 2'b00, '0, '0);
    tick();
    drive(1'b1, 1'b1, 5'd4, 1'b0, 2'b00, '0, '0);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b01, 5'd4, '0);
    check("yw_slotvld", {29'd0, if_f.slot_vld}, 32'd7);
    check("yw_stall_f", {31'd0, if_f.iss_stall}, 32'd0);
    check("yw_src", if_f.src_data[31:0], SW0);
    do_reset();

    // Flush during a load-use stall, then reset mid-stall
    drive(1'b1, 1'b1, 5'd7, 1'b1, 2'b00, '0, '0);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b10, '0, 5'd7);
    tick();
    flush = 1'b1;
    drive(1'b1, 1'b0, '0, 1'b0, 2'b10, '0, 5'd7);
    check("fl_fire", {31'd0, if_f.iss_fire}, 32'd0);
    check("fl_fire_i", {31'd0, if_i.iss_fire}, 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0, 2'b10, '0, 5'd7);
    check("fl_slotvld", {29'd0, if_f.slot_vld}, 32'd0);
    check("fl_stall", {31'd0, if_f.iss_stall}, 32'd0);
    check("fl_cnt", if_f.stall_cnt, 32'd1);
    check("fl_src1", if_f.src_data[63:32], RF1);
    drive(1'b1, 1'b1, 5'd7, 1'b1, 2'b00, '0, '0);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b10, '0, 5'd7);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 2'b10, '0, 5'd7);
    check("mr_stall_pre", {31'd0, if_f.iss_stall}, 32'd1);
    check("mr_cnt_pre", if_f.stall_cnt, 32'd2);
    resetn = 1'b0;
    #1;
    check("mr_slotvld", {29'd0, if_f.slot_vld}, 32'd0);
    check("mr_cnt", if_f.stall_cnt, 32'd0);
    check("mr_stall", {31'd0, if_f.iss_stall}, 32'd0);
    tick();
    resetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
